spi_cs_sequencer: RTL and testbench

Transaction front-end that sits directly upstream of spi_master.
- Accepts one command per SPI transaction: target chip-select, word count and an rx-keep flag.
- Owns the chip-select lines, including programmable setup, hold and inter-transaction gap delays.
- Feeds tx words one at a time into spi_master's AXIS input and takes spi_master's AXIS output, either forwarding it to the user or discarding it.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_delay_counter.sv | 30 +++
 rtl/spi_cs_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_spi_cs_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI chip-select sequencer: FSM state encoding and the
// width helper used to size the chip-select index.
package spi_pkg;

  // Sequencer states; encoding is also exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Width of an index selecting one of n lines, never less than one bit.
  function automatic int cs_sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_delay_counter.sv
// Loadable down-counter used for the chip-select setup, hold and gap timers.
// A load wins over counting; the counter parks at zero once it gets there.
module spi_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // Reload on timed-state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/spi_cs_sequencer.sv
// Transaction front-end for spi_master. Takes one command per transaction,
// drives the chip selects with setup/hold/gap timing, passes tx words one at a
// time to spi_master and forwards or discards the returned rx words.
//
// Handshakes: every AXIS-style pair (valid/ready) transfers exactly on a clock
// edge where both are high; valid never depends on ready on the producer side
// of this block, and only one tx word is ever in flight (SEND -> WAIT_RX).
module spi_cs_sequencer
  import spi_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int CS_COUNT        = 4,
  parameter int CS_SEL_WIDTH    = cs_sel_width(CS_COUNT),
  parameter int LEN_WIDTH       = 16,
  parameter int DELAY_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CS_SEL_WIDTH-1:0]    s_cmd_cs,
  input  logic [LEN_WIDTH-1:0]       s_cmd_len,
  input  logic                       s_cmd_rx_en,
  input  logic                       s_cmd_valid,
  output logic                       s_cmd_ready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_tx_tdata,
  input  logic                       s_tx_tvalid,
  output logic                       s_tx_tready,
  output logic [AXIS_DATA_WIDTH-1:0] spi_tx_tdata,
  output logic                       spi_tx_tvalid,
  input  logic                       spi_tx_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] spi_rx_tdata,
  input  logic                       spi_rx_tvalid,
  output logic                       spi_rx_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_rx_tdata,
  output logic                       m_rx_tvalid,
  input  logic                       m_rx_tready,
  input  logic [DELAY_WIDTH-1:0]     cfg_cs_setup,
  input  logic [DELAY_WIDTH-1:0]     cfg_cs_hold,
  input  logic [DELAY_WIDTH-1:0]     cfg_cs_gap,
  output logic [CS_COUNT-1:0]        cs_n,
  output logic                       busy,
  output logic                       done,
  output state_t                     dbg_state
);

  state_t                r_state;
  logic                  r_rx_en;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [DELAY_WIDTH-1:0] r_hold;
  logic [DELAY_WIDTH-1:0] r_gap;
  logic [CS_COUNT-1:0]   r_cs_n;
  logic                  r_done;

  logic                   w_cmd_hs;
  logic                   w_tx_hs;
  logic                   w_rx_hs;
  logic                   w_last;
  logic                   w_load;
  logic [DELAY_WIDTH-1:0] w_load_val;
  logic [DELAY_WIDTH-1:0] w_count;
  logic                   w_zero;
  logic [CS_COUNT-1:0]    w_cs_sel_n;

  // Command ready is gated by rst_n so it stays low while reset is asserted.
  assign s_cmd_ready = rst_n && (r_state == ST_IDLE);
  assign w_cmd_hs    = s_cmd_valid && s_cmd_ready;

  // tx path is a gated pass-through, open only in SEND.
  assign s_tx_tready   = (r_state == ST_SEND) && spi_tx_tready;
  assign spi_tx_tvalid = (r_state == ST_SEND) && s_tx_tvalid;
  assign spi_tx_tdata  = s_tx_tdata;
  assign w_tx_hs       = spi_tx_tvalid && spi_tx_tready;

  // rx path is open only in WAIT_RX; discarded words are sunk unconditionally.
  assign spi_rx_tready = (r_state == ST_WAIT_RX) && (r_rx_en ? m_rx_tready : 1'b1);
  assign m_rx_tvalid   = (r_state == ST_WAIT_RX) && r_rx_en && spi_rx_tvalid;
  assign m_rx_tdata    = spi_rx_tdata;
  assign w_rx_hs       = spi_rx_tvalid && spi_rx_tready;
  assign w_last        = (r_remaining == LEN_WIDTH'(1));

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign cs_n      = r_cs_n;
  assign dbg_state = r_state;

  // Decode the commanded CS index; an out-of-range index selects nothing.
  always_comb begin
    w_cs_sel_n = '1;
    for (int i = 0; i < CS_COUNT; i++) begin
      w_cs_sel_n[i] = (CS_SEL_WIDTH'(i) != s_cmd_cs);
    end
  end

  // Reload the shared delay timer on entry to SETUP, HOLD or GAP.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_load     = 1'b1;
          w_load_val = (s_cmd_len == '0) ? cfg_cs_gap : cfg_cs_setup;
        end
      end
      ST_WAIT_RX: begin
        if (w_rx_hs && w_last) begin
          w_load     = 1'b1;
          w_load_val = r_hold;
        end
      end
      ST_HOLD: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = r_gap;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  spi_delay_counter #(
    .WIDTH (DELAY_WIDTH)
  ) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // Transaction FSM with registered chip selects and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rx_en     <= 1'b0;
      r_remaining <= '0;
      r_hold      <= '0;
      r_gap       <= '0;
      r_cs_n      <= '1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_hs) begin
            r_rx_en     <= s_cmd_rx_en;
            r_remaining <= s_cmd_len;
            r_hold      <= cfg_cs_hold;
            r_gap       <= cfg_cs_gap;
            if (s_cmd_len == '0) begin
              r_state <= ST_GAP;
              r_done  <= (cfg_cs_gap == '0);
            end else begin
              r_state <= ST_SETUP;
              r_cs_n  <= w_cs_sel_n;
            end
          end
        end
        ST_SETUP: begin
          if (w_zero) r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_tx_hs) r_state <= ST_WAIT_RX;
        end
        ST_WAIT_RX: begin
          if (w_rx_hs) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_state     <= w_last ? ST_HOLD : ST_SEND;
          end
        end
        ST_HOLD: begin
          if (w_zero) begin
            r_state <= ST_GAP;
            r_cs_n  <= '1;
            r_done  <= (r_gap == '0);
          end
        end
        ST_GAP: begin
          // done is lined up with the cycle in which the timer reads zero.
          if (w_zero) r_state <= ST_IDLE;
          else        r_done  <= (w_count == DELAY_WIDTH'(1));
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer with a one-word-at-a-time spi_master
// stub that echoes the bitwise inverse of each tx word after two cycles.
module tb_spi_cs_sequencer;
  import spi_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  s_cmd_cs;
  logic [15:0] s_cmd_len;
  logic        s_cmd_rx_en, s_cmd_valid, s_cmd_ready;
  logic [W-1:0] s_tx_tdata, spi_tx_tdata, spi_rx_tdata, m_rx_tdata;
  logic s_tx_tvalid, s_tx_tready, spi_tx_tvalid, spi_tx_tready;
  logic spi_rx_tvalid, spi_rx_tready, m_rx_tvalid, m_rx_tready;
  logic [7:0] cfg_cs_setup, cfg_cs_hold, cfg_cs_gap;
  logic [3:0] cs_n;
  logic busy, done;
  state_t dbg_state;

  spi_cs_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_cs(s_cmd_cs), .s_cmd_len(s_cmd_len), .s_cmd_rx_en(s_cmd_rx_en),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_tx_tdata(s_tx_tdata), .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready),
    .spi_tx_tdata(spi_tx_tdata), .spi_tx_tvalid(spi_tx_tvalid), .spi_tx_tready(spi_tx_tready),
    .spi_rx_tdata(spi_rx_tdata), .spi_rx_tvalid(spi_rx_tvalid), .spi_rx_tready(spi_rx_tready),
    .m_rx_tdata(m_rx_tdata), .m_rx_tvalid(m_rx_tvalid), .m_rx_tready(m_rx_tready),
    .cfg_cs_setup(cfg_cs_setup), .cfg_cs_hold(cfg_cs_hold), .cfg_cs_gap(cfg_cs_gap),
    .cs_n(cs_n), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_got[$];

  // ---------------- monitor (samples 2 time units before each rising edge) ----------------
  logic f_tx_hs = 0, f_s_tx_hs = 0, f_rx_hs = 0;
  logic [W-1:0] f_tx_data = '0;
  int cyc = 0, cmd_cyc = -1, cs_fall_cyc = -1, cs_rise_cyc = -1, txv_first_cyc = -1;
  int last_rx_hs_cyc = -1, done_cyc = -10, done_cnt = 0, mrx_v_cnt = 0, cs_bad = 0;
  int rx_hs_cnt = 0, stall_cnt = 0, bp_rdy_cnt = 0, bp_txv_cnt = 0;
  logic [3:0] exp_cs = 4'hF;
  logic busy_at_done, busy_after, ready_after;
  logic bp_win = 1'b0;

  always @(negedge clk) begin
    #3;
    cyc = cyc + 1;
    f_tx_hs   = spi_tx_tvalid && spi_tx_tready;
    f_tx_data = spi_tx_tdata;
    f_s_tx_hs = s_tx_tvalid && s_tx_tready;
    f_rx_hs   = spi_rx_tvalid && spi_rx_tready;
    if (s_cmd_valid && s_cmd_ready) cmd_cyc = cyc;
    if (cs_n != 4'hF) begin
      if (cs_fall_cyc < 0) cs_fall_cyc = cyc;
      if (cs_n != exp_cs) cs_bad++;
    end else if (cs_fall_cyc >= 0 && cs_rise_cyc < 0) begin
      cs_rise_cyc = cyc;
    end
    if (spi_tx_tvalid && txv_first_cyc < 0) txv_first_cyc = cyc;
    if (f_rx_hs) begin last_rx_hs_cyc = cyc; rx_hs_cnt++; end
    if (spi_rx_tvalid && !spi_rx_tready) stall_cnt++;
    if (m_rx_tvalid) mrx_v_cnt++;
    if (m_rx_tvalid && m_rx_tready) rx_got.push_back(m_rx_tdata);
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (cyc == done_cyc + 1) begin busy_after = busy; ready_after = s_cmd_ready; end
    if (bp_win && spi_rx_tready) bp_rdy_cnt++;
    if (bp_win && spi_tx_tvalid) bp_txv_cnt++;
  end

  // ---------------- spi_master stub ----------------
  logic [W-1:0] stub_data;
  int stub_cnt;
  initial begin
    spi_tx_tready = 1'b1; spi_rx_tvalid = 1'b0; spi_rx_tdata = '0;
    stub_data = '0; stub_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi_tx_tready = 1'b1; spi_rx_tvalid = 1'b0; stub_cnt = 0;
      end else begin
        if (f_rx_hs) begin spi_rx_tvalid = 1'b0; spi_tx_tready = 1'b1; end
        if (f_tx_hs) begin
          stub_data = ~f_tx_data; stub_cnt = 2; spi_tx_tready = 1'b0;
        end else if (stub_cnt > 0) begin
          stub_cnt--;
          if (stub_cnt == 0) begin spi_rx_tvalid = 1'b1; spi_rx_tdata = stub_data; end
        end
      end
    end
  end

  // ---------------- tx word feeder ----------------
  initial begin
    s_tx_tvalid = 1'b0; s_tx_tdata = '0;
    forever begin
      @(negedge clk);
      if (f_s_tx_hs && tx_q.size() > 0) void'(tx_q.pop_front());
      if (!rst_n) tx_q.delete();
      s_tx_tvalid = (tx_q.size() > 0);
      s_tx_tdata  = (tx_q.size() > 0) ? tx_q[0] : '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_track(input logic [3:0] cs_pat);
    exp_cs = cs_pat; cmd_cyc = -1; cs_fall_cyc = -1; cs_rise_cyc = -1; txv_first_cyc = -1;
    last_rx_hs_cyc = -1; done_cyc = -10; done_cnt = 0; mrx_v_cnt = 0; cs_bad = 0;
    rx_hs_cnt = 0; stall_cnt = 0; bp_rdy_cnt = 0; bp_txv_cnt = 0;
    busy_at_done = 1'bx; busy_after = 1'bx; ready_after = 1'bx;
    rx_got.delete(); exp_q.delete();
  endtask

  task automatic send_cmd(input logic [1:0] cs, input logic [15:0] len, input logic rx_en,
                          input logic [7:0] su, input logic [7:0] ho, input logic [7:0] ga);
    int n = 0;
    @(negedge clk);
    s_cmd_cs = cs; s_cmd_len = len; s_cmd_rx_en = rx_en;
    cfg_cs_setup = su; cfg_cs_hold = ho; cfg_cs_gap = ga; s_cmd_valid = 1'b1;
    #1;
    while (!s_cmd_ready && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL cmd_accept_timeout: ready low for %0d cycles", n); end
    @(negedge clk);
    // Scramble every command field so later timing proves the values were latched.
    s_cmd_valid = 1'b0; s_cmd_cs = ~cs; s_cmd_len = 16'hFFFF; s_cmd_rx_en = ~rx_en;
    cfg_cs_setup = 8'd200; cfg_cs_hold = 8'd200; cfg_cs_gap = 8'd200;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt == 0) begin failures++; $display("FAIL %s_done_timeout: no done in %0d cycles", nm, n); end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_rx(input string nm);
    checks++;
    if (rx_got.size() != exp_q.size()) begin
      failures++; $display("FAIL %s_rx_count: got %0d words want %0d", nm, rx_got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= rx_got.size() || rx_got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_rx_word%0d: got %h want %h", nm, i, (i < rx_got.size()) ? rx_got[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cs_n !== 4'hF) begin failures++; $display("FAIL rst_cs_n: got %b want 1111", cs_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (s_cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %b want 0", s_cmd_ready); end
    checks++; if (spi_tx_tvalid !== 1'b0 || s_tx_tready !== 1'b0) begin failures++; $display("FAIL rst_tx_hs: got v=%b r=%b want 0 0", spi_tx_tvalid, s_tx_tready); end
    checks++; if (spi_rx_tready !== 1'b0 || m_rx_tvalid !== 1'b0) begin failures++; $display("FAIL rst_rx_hs: got r=%b v=%b want 0 0", spi_rx_tready, m_rx_tvalid); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (s_cmd_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", s_cmd_ready); end
  endtask

  task automatic test_basic();
    clear_track(4'b1011);
    tx_q.push_back(8'hA1); tx_q.push_back(8'hB2); tx_q.push_back(8'hC3);
    exp_q.push_back(8'h5E); exp_q.push_back(8'h4D); exp_q.push_back(8'h3C);
    send_cmd(2'd2, 16'd3, 1'b1, 8'd2, 8'd1, 8'd0);
    wait_done("basic");
    check_rx("basic");
    checks++; if (cs_bad != 0) begin failures++; $display("FAIL basic_cs_pattern: got %0d bad cycles want 0", cs_bad); end
    checks++; if (cs_fall_cyc != cmd_cyc + 1) begin failures++; $display("FAIL basic_cs_fall: got %0d want %0d", cs_fall_cyc - cmd_cyc, 1); end
    checks++; if (txv_first_cyc - cs_fall_cyc != 3) begin failures++; $display("FAIL basic_setup_len: got %0d want 3", txv_first_cyc - cs_fall_cyc); end
    checks++; if (cs_rise_cyc - last_rx_hs_cyc != 3) begin failures++; $display("FAIL basic_hold_len: got %0d want 3", cs_rise_cyc - last_rx_hs_cyc); end
    checks++; if (done_cyc - cs_rise_cyc != 0) begin failures++; $display("FAIL basic_gap_len: got %0d want 0", done_cyc - cs_rise_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_fall: got %b%b want 10", busy_at_done, busy_after); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b want 1", ready_after); end
  endtask

  task automatic test_discard();
    clear_track(4'b1110);
    m_rx_tready = 1'b0;
    tx_q.push_back(8'h10); tx_q.push_back(8'h20);
    send_cmd(2'd0, 16'd2, 1'b0, 8'd1, 8'd0, 8'd2);
    wait_done("discard");
    m_rx_tready = 1'b1;
    checks++; if (mrx_v_cnt != 0) begin failures++; $display("FAIL discard_mrx_valid: got %0d cycles want 0", mrx_v_cnt); end
    checks++; if (rx_got.size() != 0) begin failures++; $display("FAIL discard_rx_words: got %0d want 0", rx_got.size()); end
    checks++; if (stall_cnt != 0) begin failures++; $display("FAIL discard_rx_ready: got %0d stalled cycles want 0", stall_cnt); end
    checks++; if (rx_hs_cnt != 2) begin failures++; $display("FAIL discard_rx_hs: got %0d want 2", rx_hs_cnt); end
    checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL discard_tx_left: got %0d want 0", tx_q.size()); end
    checks++; if (done_cyc - cs_rise_cyc != 2) begin failures++; $display("FAIL discard_gap_len: got %0d want 2", done_cyc - cs_rise_cyc); end
    checks++; if (cs_bad != 0) begin failures++; $display("FAIL discard_cs_pattern: got %0d want 0", cs_bad); end
  endtask

  task automatic test_delays();
    clear_track(4'b0111);
    tx_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    send_cmd(2'd3, 16'd1, 1'b1, 8'd0, 8'd0, 8'd0);
    wait_done("dly0");
    check_rx("dly0");
    checks++; if (txv_first_cyc - cs_fall_cyc != 1) begin failures++; $display("FAIL dly0_setup: got %0d want 1", txv_first_cyc - cs_fall_cyc); end
    checks++; if (cs_rise_cyc - last_rx_hs_cyc != 2) begin failures++; $display("FAIL dly0_hold: got %0d want 2", cs_rise_cyc - last_rx_hs_cyc); end
    checks++; if (done_cyc - cs_rise_cyc != 0) begin failures++; $display("FAIL dly0_gap: got %0d want 0", done_cyc - cs_rise_cyc); end

    clear_track(4'b1101);
    tx_q.push_back(8'h96); exp_q.push_back(8'h69);
    send_cmd(2'd1, 16'd1, 1'b1, 8'd5, 8'd3, 8'd4);
    wait_done("dly5");
    check_rx("dly5");
    checks++; if (txv_first_cyc - cs_fall_cyc != 6) begin failures++; $display("FAIL dly5_setup: got %0d want 6", txv_first_cyc - cs_fall_cyc); end
    checks++; if (cs_rise_cyc - last_rx_hs_cyc != 5) begin failures++; $display("FAIL dly5_hold: got %0d want 5", cs_rise_cyc - last_rx_hs_cyc); end
    checks++; if (done_cyc - cs_rise_cyc != 4) begin failures++; $display("FAIL dly5_gap: got %0d want 4", done_cyc - cs_rise_cyc); end
    checks++; if (cs_bad != 0) begin failures++; $display("FAIL dly5_cs_pattern: got %0d want 0", cs_bad); end
  endtask

  task automatic test_zero_len();
    clear_track(4'b1011);
    send_cmd(2'd2, 16'd0, 1'b1, 8'd7, 8'd7, 8'd3);
    wait_done("zero");
    checks++; if (cs_fall_cyc != -1) begin failures++; $display("FAIL zero_cs_asserted: got cycle %0d want never", cs_fall_cyc); end
    checks++; if (done_cyc - cmd_cyc != 4) begin failures++; $display("FAIL zero_done_delay: got %0d want 4", done_cyc - cmd_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    checks++; if (busy_after !== 1'b0 || ready_after !== 1'b1) begin failures++; $display("FAIL zero_idle_after: got busy=%b ready=%b want 0 1", busy_after, ready_after); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_track(4'b1110);
    m_rx_tready = 1'b0;
    tx_q.push_back(8'h11); tx_q.push_back(8'h22);
    exp_q.push_back(8'hEE); exp_q.push_back(8'hDD);
    send_cmd(2'd0, 16'd2, 1'b1, 8'd0, 8'd0, 8'd0);
    while (!spi_rx_tvalid && n < 100) begin @(negedge clk); #4; n++; end
    checks++; if (!spi_rx_tvalid) begin failures++; $display("FAIL bp_rx_timeout: rx word never offered in %0d cycles", n); end
    bp_win = 1'b1;
    repeat (10) @(negedge clk);
    bp_win = 1'b0;
    m_rx_tready = 1'b1;
    wait_done("bp");
    check_rx("bp");
    checks++; if (bp_rdy_cnt != 0) begin failures++; $display("FAIL bp_spi_rx_ready: got %0d ready cycles want 0", bp_rdy_cnt); end
    checks++; if (bp_txv_cnt != 0) begin failures++; $display("FAIL bp_tx_valid: got %0d valid cycles want 0", bp_txv_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_track(4'b1101);
    tx_q.push_back(8'h01);
    send_cmd(2'd1, 16'd3, 1'b1, 8'd0, 8'd0, 8'd0);
    while (rx_got.size() < 1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (rx_got.size() != 1 || rx_got[0] !== 8'hFE) begin failures++; $display("FAIL rmid_first_word: got %0d words want 1 (FE)", rx_got.size()); end
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    checks++; if (cs_n !== 4'hF) begin failures++; $display("FAIL rmid_cs_async: got %b want 1111", cs_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(negedge clk); #1; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end

    clear_track(4'b0111);
    tx_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    send_cmd(2'd3, 16'd1, 1'b1, 8'd1, 8'd0, 8'd1);
    wait_done("rmid_next");
    check_rx("rmid_next");
    checks++; if (cs_bad != 0 || cs_fall_cyc != cmd_cyc + 1) begin failures++; $display("FAIL rmid_next_cs: got bad=%0d fall=%0d want 0 1", cs_bad, cs_fall_cyc - cmd_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rmid_next_done: got %0d want 1", done_cnt); end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    s_cmd_cs = '0; s_cmd_len = '0; s_cmd_rx_en = 1'b0; s_cmd_valid = 1'b0;
    cfg_cs_setup = '0; cfg_cs_hold = '0; cfg_cs_gap = '0; m_rx_tready = 1'b1;
    test_reset();
    test_basic();
    test_discard();
    test_delays();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a scenario wedges outside its own bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
